alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 9 +
 rtl/alu_mul_iter.sv | 39 +++
 rtl/alu_seq.sv | 98 +++++++++
 tb/tb_alu_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, FSM state type and illegal-result fill shared by the ALU
package alu_pkg;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h4;
    localparam logic [3:0] OP_MOD3 = 4'h8;
    localparam logic [31:0] ILLEGAL_RESULT = '1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: WIDTH-cycle shift-add multiplier; done marks the final step and prod is that step's result
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum;
    // one step: add the multiplicand into the upper half when the current multiplier bit is set, then shift right
    always_comb begin
        sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        prod = {sum, acc[WIDTH-1:1]};
        done = cnt == CW'(1);
    end
    // load operands on start, then take one step per cycle until the count runs out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mcand <= '0;
            cnt   <= '0;
        end else if (start) begin
            acc   <= {{WIDTH{1'b0}}, b};
            mcand <= a;
            cnt   <= CW'(WIDTH);
        end else if (cnt != '0) begin
            acc <= prod;
            cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU (add/sub/iterative mul/mod3); mod3 present only with ALU_SEQ_MOD3_EN
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int OP_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] opcode,
    input  logic [WIDTH-1:0]    num_1,
    input  logic [WIDTH-1:0]    num_2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    ans,
    output logic [WIDTH-1:0]    ans_hi,
    output logic                carry,
    output logic                zero,
    output logic                err
);
    state_t               state, state_nx;
    logic                 accept, is_add, is_sub, is_mul, is_mod3, mul_done, load;
    logic [2*WIDTH-1:0]   mul_prod;
    logic [WIDTH:0]       sum, diff;
    logic [WIDTH-1:0]     mod3_val, res_lo, res_hi;
    logic                 res_c, res_e;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    assign is_add    = opcode == OP_WIDTH'(OP_ADD);
    assign is_sub    = opcode == OP_WIDTH'(OP_SUB);
    assign is_mul    = opcode == OP_WIDTH'(OP_MUL);
`ifdef ALU_SEQ_MOD3_EN
    assign is_mod3   = opcode == OP_WIDTH'(OP_MOD3);
    assign mod3_val  = num_1 % WIDTH'(3);
`else
    assign is_mod3   = 1'b0;
    assign mod3_val  = '0;
`endif
    assign load      = (accept && !is_mul) || (state == CALC && mul_done);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && is_mul),
        .a     (num_1),
        .b     (num_2),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // state register; reset abandons any multiply in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state: single-cycle ops go straight to DONE, multiply waits for the iterator
    always_comb begin
        state_nx = state == IDLE ? (accept ? (is_mul ? CALC : DONE) : IDLE)
                 : state == CALC ? (mul_done ? DONE : CALC)
                 : (out_ready ? IDLE : DONE);
    end

    // result selection: in CALC the only result being captured is the product
    always_comb begin
        sum    = {1'b0, num_1} + {1'b0, num_2};
        diff   = {1'b0, num_1} - {1'b0, num_2};
        res_lo = state == CALC ? mul_prod[WIDTH-1:0]
               : is_add ? sum[WIDTH-1:0]
               : is_sub ? diff[WIDTH-1:0]
               : is_mod3 ? mod3_val
               : ILLEGAL_RESULT[WIDTH-1:0];
        res_hi = state == CALC ? mul_prod[2*WIDTH-1:WIDTH] : '0;
        res_c  = state != CALC && (is_add ? sum[WIDTH] : is_sub && diff[WIDTH]);
        res_e  = state != CALC && !(is_add || is_sub || is_mod3);
    end

    // result registers hold until the next command completes, keeping outputs stable under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ans    <= '0;
            ans_hi <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            err    <= 1'b0;
        end else if (load) begin
            ans    <= res_lo;
            ans_hi <= res_hi;
            carry  <= res_c;
            zero   <= res_lo == '0 && res_hi == '0;
            err    <= res_e;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: random and directed stimulus against an arithmetic reference model of alu_seq
module tb_alu_seq;
    localparam int W = 8;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0] opcode = '0;
    logic [W-1:0] num_1 = '0, num_2 = '0;
    logic in_ready, out_valid, carry, zero, err;
    logic [W-1:0] ans, ans_hi;
    int checks = 0, passes = 0;

    alu_seq #(.WIDTH(W), .OP_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .num_1(num_1), .num_2(num_2), .out_valid(out_valid),
        .out_ready(out_ready), .ans(ans), .ans_hi(ans_hi), .carry(carry),
        .zero(zero), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void ref_calc(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] lo, output logic [W-1:0] hi,
                                     output logic c, output logic e, output int lat);
        int unsigned x, y, p;
        x = a; y = b; lo = '0; hi = '0; c = 1'b0; e = 1'b0; lat = 1;
        if (op == 4'h1) begin
            p = x + y; lo = W'(p); c = p >= (1 << W);
        end else if (op == 4'h2) begin
            p = x - y; lo = W'(p); c = y > x;
        end else if (op == 4'h4) begin
            p = x * y; lo = W'(p); hi = W'(p >> W); lat = W + 1;
`ifdef ALU_SEQ_MOD3_EN
        end else if (op == 4'h8) begin
            lo = W'(x % 3);
`endif
        end else begin
            lo = '1; e = 1'b1;
        end
    endfunction

    // reference model: result appears lat edges after acceptance (the accepting edge counts as the first)
    logic [W-1:0] m_lo = '0, m_hi = '0;
    logic m_c = 1'b0, m_e = 1'b0;
    bit m_pend = 0, m_hold = 0;
    int m_wait = 0, m_lat;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 0; m_hold = 0; m_wait = 0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 0;
        end else if (m_pend) begin
            m_wait--;
            if (m_wait == 0) begin m_pend = 0; m_hold = 1; end
        end else if (in_valid) begin
            ref_calc(opcode, num_1, num_2, m_lo, m_hi, m_c, m_e, m_lat);
            m_wait = m_lat - 1;
            if (m_wait == 0) m_hold = 1; else m_pend = 1;
        end
    end

    // every cycle out of reset: handshake flags always, result fields while a result is presented
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", out_valid, m_hold);
            chk("in_ready", in_ready, !(m_pend || m_hold));
            if (m_hold) begin
                chk("ans", ans, m_lo);
                chk("ans_hi", ans_hi, m_hi);
                chk("carry", carry, m_c);
                chk("err", err, m_e);
                chk("zero", zero, m_lo == '0 && m_hi == '0);
            end
        end
    end

    task automatic accept_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin checks++; $display("FAIL accept_timeout: in_ready 0 expected 1"); end
        in_valid = 1'b1; opcode = op; num_1 = a; num_2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0; opcode = 4'($urandom); num_1 = W'($urandom); num_2 = W'($urandom);
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        accept_cmd(op, a, b);
        lat = 1;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        if (!out_valid) begin checks++; $display("FAIL result_timeout: out_valid 0 expected 1"); end
    endtask

    task automatic consume();
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    initial begin
        int lat, k, sel;
        logic [3:0] op;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ans", ans, 0);
        chk("rst_ans_hi", ans_hi, 0);
        chk("rst_carry", carry, 0);
        chk("rst_zero", zero, 0);
        chk("rst_err", err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);

        issue(4'h1, 8'hF0, 8'h20, lat);
        chk("add_lat", lat, 1); chk("add_ans", ans, 8'h10); chk("add_carry", carry, 1); chk("add_zero", zero, 0);
        consume();
        issue(4'h2, 8'h05, 8'h07, lat);
        chk("sub_ans", ans, 8'hFE); chk("sub_borrow", carry, 1);
        consume();
        issue(4'h2, 8'h07, 8'h07, lat);
        chk("sub0_ans", ans, 8'h00); chk("sub0_zero", zero, 1); chk("sub0_carry", carry, 0);
        consume();
        issue(4'h4, 8'hFF, 8'hFF, lat);
        chk("mul_lat", lat, 9); chk("mul_hi", ans_hi, 8'hFE); chk("mul_lo", ans, 8'h01); chk("mul_err", err, 0);
        consume();
        issue(4'h8, 8'd200, 8'h00, lat);
`ifdef ALU_SEQ_MOD3_EN
        chk("mod3_ans", ans, 8'h02); chk("mod3_err", err, 0);
`else
        chk("mod3_off_ans", ans, 8'hFF); chk("mod3_off_err", err, 1);
`endif
        consume();
        issue(4'h3, 8'h12, 8'h34, lat);
        chk("ill_ans", ans, 8'hFF); chk("ill_err", err, 1); chk("ill_hi", ans_hi, 0); chk("ill_carry", carry, 0);
        consume();

        issue(4'h1, 8'h12, 8'h34, lat);
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1; opcode = 4'h4; num_1 = W'($urandom); num_2 = W'($urandom);
        end
        #1;
        chk("bp_ans", ans, 8'h46); chk("bp_in_ready", in_ready, 0); chk("bp_out_valid", out_valid, 1);
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", in_ready, 1); chk("bp_release_valid", out_valid, 0);
        @(negedge clk); out_ready = 1'b0;

        accept_cmd(4'h4, 8'hA5, 8'h3C);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", out_valid, 0); chk("mrst_ans", ans, 0); chk("mrst_ans_hi", ans_hi, 0);
        chk("mrst_carry", carry, 0); chk("mrst_zero", zero, 0); chk("mrst_err", err, 0);
        chk("mrst_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        issue(4'h1, 8'h03, 8'h04, lat);
        chk("post_rst_lat", lat, 1); chk("post_rst_ans", ans, 8'h07);
        consume();

        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 5);
            op = sel == 0 ? 4'h1 : sel == 1 ? 4'h2 : sel == 2 ? 4'h4 : sel == 3 ? 4'h8 : sel == 4 ? 4'($urandom) : 4'h1;
            issue(op, W'($urandom), W'($urandom), lat);
            k = $urandom_range(0, 3);
            repeat (k) begin
                @(negedge clk);
                in_valid = 1'($urandom); opcode = 4'($urandom); num_1 = W'($urandom); num_2 = W'($urandom);
            end
            consume();
        end
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
